// File: rtl/countdown_timer_if.sv
// Host-side bundle for the countdown timer: load/enable controls in,
// count, terminal-count pulse and busy status out.
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    modport master (
        output load, load_val, en,
        input  q, tc, busy
    );

    modport slave (
        input  load, load_val, en,
        output q, tc, busy
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse; optionally
// reloads itself on expiry to act as a periodic tick source.
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload;

    function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
        return v - ONE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            reload   <= '0;
            bus.q    <= '0;
            bus.tc   <= 1'b0;
            bus.busy <= 1'b0;
        end else if (bus.load) begin
            // A load overrides everything, including a simultaneous expiry.
            bus.q  <= bus.load_val;
            reload <= bus.load_val;
            bus.tc <= 1'b0;
            if (bus.load_val != '0) begin
                state    <= RUN;
                bus.busy <= 1'b1;
            end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (bus.en && bus.q == ONE) begin
                        bus.tc <= 1'b1;
                        if (AUTO_RELOAD) begin
                            bus.q <= reload;
                        end else begin
                            bus.q    <= '0;
                            state    <= EXPIRED;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        // Guard on nonzero so the count can never wrap to max.
                        if (bus.en && bus.q != '0)
                            bus.q <= dec(bus.q);
                        bus.tc <= 1'b0;
                    end
                end
                EXPIRED: begin
                    state    <= IDLE;
                    bus.tc   <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.tc   <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
